// File: rtl/mac_tx_frame_gen_if.sv
// mac_tx_frame_gen_if: MAC transmit byte stream (data/valid/sof/eof) towards mac_rgmii.
interface mac_tx_frame_gen_if;
    logic [7:0] mac_tx_data;
    logic       mac_tx_valid;
    logic       mac_tx_sof;
    logic       mac_tx_eof;
    modport master (output mac_tx_data, mac_tx_valid, mac_tx_sof, mac_tx_eof);
    modport slave  (input  mac_tx_data, mac_tx_valid, mac_tx_sof, mac_tx_eof);
endinterface

// File: rtl/mac_tx_frame_gen.sv
// mac_tx_frame_gen: Ethernet test-frame generator (header, sequence-numbered payload, optional FCS).
module mac_tx_frame_gen #(
    parameter logic [47:0] DST_MAC    = 48'hFFFF_FFFF_FFFF,
    parameter logic [47:0] SRC_MAC    = 48'h000A_3500_0001,
    parameter logic [15:0] ETHERTYPE  = 16'h88B5,
    parameter int unsigned IFG_CYCLES = 12,
    parameter bit          APPEND_FCS = 1'b1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      enable,
    input  logic [10:0]               payload_len,
    mac_tx_frame_gen_if.master        tx,
    output logic                      busy,
    output logic [31:0]               frame_cnt
);
    typedef enum logic [2:0] {IDLE, HDR, PAY, FCS, IFG} state_t;
    localparam logic [111:0] HDR_BYTES = {DST_MAC, SRC_MAC, ETHERTYPE};
    localparam logic [10:0]  IFG_LAST  = 11'(IFG_CYCLES) - 11'd1;
    localparam state_t       POST      = (IFG_CYCLES == 0) ? IDLE : IFG;

    state_t      r_state, w_state_nxt;
    logic [10:0] r_idx, w_idx_nxt, r_len, w_len_clamp;
    logic [31:0] r_seq, r_crc, r_frame_cnt, w_fcs;
    logic [7:0]  w_byte;
    logic        w_eof, w_valid;

    function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] x;
        x = c ^ {24'd0, d};
        for (int i = 0; i < 8; i++) x = x[0] ? ((x >> 1) ^ 32'hEDB8_8320) : (x >> 1);
        return x;
    endfunction

    assign w_len_clamp = (payload_len < 11'd46) ? 11'd46 : (payload_len > 11'd1500) ? 11'd1500 : payload_len;
    assign w_fcs       = ~r_crc;

    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx + 11'd1;
        w_byte      = 8'd0;
        w_eof       = 1'b0;
        case (r_state)
            IDLE: begin
                w_idx_nxt = 11'd0;
                if (enable) w_state_nxt = HDR;
            end
            HDR: begin
                w_byte = HDR_BYTES[7'd104 - {r_idx[3:0], 3'b000} +: 8];
                if (r_idx == 11'd13) begin
                    w_state_nxt = PAY;
                    w_idx_nxt   = 11'd0;
                end
            end
            PAY: begin
                // first four payload bytes carry the sequence number, the rest count up
                w_byte = (r_idx < 11'd4) ? r_seq[5'd24 - {r_idx[1:0], 3'b000} +: 8] : r_idx[7:0];
                if (r_idx == r_len - 11'd1) begin
                    w_state_nxt = APPEND_FCS ? FCS : POST;
                    w_idx_nxt   = 11'd0;
                    w_eof       = !APPEND_FCS;
                end
            end
            FCS: begin
                w_byte = w_fcs[{r_idx[1:0], 3'b000} +: 8];
                if (r_idx == 11'd3) begin
                    w_state_nxt = POST;
                    w_idx_nxt   = 11'd0;
                    w_eof       = 1'b1;
                end
            end
            IFG: begin
                if (r_idx == IFG_LAST) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_idx   <= 11'd0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_len       <= 11'd46;
            r_seq       <= 32'd0;
            r_crc       <= 32'hFFFF_FFFF;
            r_frame_cnt <= 32'd0;
        end else begin
            if (r_state == IDLE && enable) begin
                r_len <= w_len_clamp;
                r_seq <= r_frame_cnt;
            end
            // CRC covers header and payload; it is frozen while the FCS is sent
            r_crc <= (r_state == IDLE) ? 32'hFFFF_FFFF :
                     (r_state == HDR || r_state == PAY) ? crc_byte(r_crc, w_byte) : r_crc;
            if (w_eof) r_frame_cnt <= r_frame_cnt + 32'd1;
        end
    end

    assign w_valid         = (r_state == HDR) || (r_state == PAY) || (r_state == FCS);
    assign tx.mac_tx_valid = w_valid;
    assign tx.mac_tx_data  = w_byte;
    assign tx.mac_tx_sof   = (r_state == HDR) && (r_idx == 11'd0);
    assign tx.mac_tx_eof   = w_eof;
    assign busy            = (r_state != IDLE);
    assign frame_cnt       = r_frame_cnt;
endmodule

// File: tb/tb_mac_tx_frame_gen.sv
// tb_mac_tx_frame_gen: scoreboard bench; dut_a uses defaults, dut_b has no FCS and zero IFG.
module tb_mac_tx_frame_gen;
    logic        clk = 1'b0, rst = 1'b1;
    logic        en_a = 1'b0, en_b = 1'b0;
    logic [10:0] len_a = 11'd46, len_b = 11'd46;
    logic        busy_a, busy_b;
    logic [31:0] cnt_a, cnt_b;

    mac_tx_frame_gen_if if_a();
    mac_tx_frame_gen_if if_b();

    mac_tx_frame_gen dut_a (.clk(clk), .rst(rst), .enable(en_a), .payload_len(len_a),
                            .tx(if_a), .busy(busy_a), .frame_cnt(cnt_a));
    mac_tx_frame_gen #(.IFG_CYCLES(0), .APPEND_FCS(1'b0)) dut_b (
        .clk(clk), .rst(rst), .enable(en_b), .payload_len(len_b),
        .tx(if_b), .busy(busy_b), .frame_cnt(cnt_b));

    always #4 clk = ~clk;

    typedef struct { int d; int len; logic [31:0] seq; int gap; } exp_t;
    typedef struct { int plen; int exp_len; } vec_t;

    exp_t        sb[$];
    exp_t        cur [2];
    bit          has_cur [2];
    int          tests = 0, failed = 0;
    logic [31:0] exp_cnt [2];
    logic [7:0]  cap [2][1600];
    int          cap_n [2];
    int          gap [2];
    int          sofs [2];
    bit          in_frame [2];
    bit          idle_bad [2];

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] crc_upd(logic [31:0] c, logic [7:0] b);
        logic fb;
        for (int i = 0; i < 8; i++) begin
            fb = c[0] ^ b[i];
            c  = {1'b0, c[31:1]} ^ (fb ? 32'hEDB8_8320 : 32'd0);
        end
        return c;
    endfunction

    function automatic logic [7:0] model_byte(int k, logic [31:0] seq);
        logic [111:0] h;
        int j;
        h = {48'hFFFF_FFFF_FFFF, 48'h000A_3500_0001, 16'h88B5};
        if (k < 14) return h[111 - 8 * k -: 8];
        j = k - 14;
        if (j < 4) return seq[31 - 8 * j -: 8];
        return j[7:0];
    endfunction

    task automatic check_frame(int d);
        exp_t e;
        int n, first, mism;
        logic [31:0] c, fcs;
        logic [7:0] m, gb, eb;
        e = cur[d];
        n = 14 + e.len + ((d == 0) ? 4 : 0);
        chk($sformatf("frame_len d%0d seq %0h", d, e.seq), cap_n[d], n);
        c = 32'hFFFF_FFFF; first = -1; mism = 0; gb = 8'd0; eb = 8'd0;
        for (int k = 0; k < n && k < cap_n[d] && k < 1600; k++) begin
            if (k < 14 + e.len) begin
                m = model_byte(k, e.seq);
                c = crc_upd(c, m);
            end else begin
                fcs = ~c;
                m = fcs[8 * (k - 14 - e.len) +: 8];
            end
            if (cap[d][k] !== m) begin
                mism++;
                if (first < 0) begin first = k; gb = cap[d][k]; eb = m; end
            end
        end
        chk($sformatf("frame_bytes d%0d seq %0h first_bad@%0d got %0h want %0h", d, e.seq, first, gb, eb), mism, 0);
    endtask

    task automatic mon(int d, logic v, logic s, logic e, logic [7:0] x);
        if (rst) begin
            in_frame[d] = 0; has_cur[d] = 0; gap[d] = -1; idle_bad[d] = 0;
        end else if (!v) begin
            if (in_frame[d]) chk($sformatf("valid_continuous d%0d", d), v, 1);
            in_frame[d] = 0;
            if (x != 8'd0 || s || e) idle_bad[d] = 1;
            if (gap[d] >= 0) gap[d]++;
        end else begin
            if (s) begin
                chk($sformatf("sof_only_first d%0d", d), in_frame[d], 0);
                chk($sformatf("idle_outputs_zero d%0d", d), idle_bad[d], 0);
                sofs[d]++;
                has_cur[d] = 0;
                chk($sformatf("frame_expected d%0d", d), sb.size() != 0, 1);
                if (sb.size() != 0) begin
                    cur[d] = sb.pop_front();
                    has_cur[d] = 1;
                    chk("frame_on_right_dut", cur[d].d, d);
                    if (cur[d].gap >= 0) chk($sformatf("idle_gap d%0d", d), gap[d], cur[d].gap);
                end
                cap_n[d] = 0; in_frame[d] = 1; idle_bad[d] = 0;
            end else if (!in_frame[d]) begin
                chk($sformatf("byte_outside_frame d%0d", d), in_frame[d], 1);
            end
            if (in_frame[d]) begin
                if (cap_n[d] < 1600) cap[d][cap_n[d]] = x;
                cap_n[d]++;
                if (e) begin
                    if (has_cur[d]) check_frame(d);
                    in_frame[d] = 0; has_cur[d] = 0; gap[d] = 0;
                end
            end
        end
    endtask

    always @(negedge clk) begin
        mon(0, if_a.mac_tx_valid, if_a.mac_tx_sof, if_a.mac_tx_eof, if_a.mac_tx_data);
        mon(1, if_b.mac_tx_valid, if_b.mac_tx_sof, if_b.mac_tx_eof, if_b.mac_tx_data);
    end

    task automatic tick(int n = 1);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic push(int d, int len, int gap_exp);
        sb.push_back('{d, len, exp_cnt[d], gap_exp});
        exp_cnt[d]++;
    endtask

    task automatic pulse_a();
        en_a = 1'b1; tick(); en_a = 1'b0;
    endtask

    task automatic wait_drain(int budget);
        int k = 0;
        while ((sb.size() != 0 || in_frame[0] || in_frame[1]) && k < budget) begin tick(); k++; end
        chk("drain_timeout", (sb.size() != 0 || in_frame[0] || in_frame[1]), 0);
    endtask

    task automatic wait_idle(int budget);
        int k = 0;
        while ((busy_a || busy_b) && k < budget) begin tick(); k++; end
        chk("idle_timeout", busy_a || busy_b, 0);
    endtask

    task automatic wait_bytes(int d, int n, int budget);
        int k = 0;
        while (!(in_frame[d] && cap_n[d] >= n) && k < budget) begin tick(); k++; end
        chk("bytes_timeout", in_frame[d] && cap_n[d] >= n, 1);
    endtask

    task automatic wait_sofs(int d, int n, int budget);
        int k = 0;
        while (sofs[d] < n && k < budget) begin tick(); k++; end
        chk("sof_timeout", sofs[d] >= n, 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", tests, failed + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl [9];
        int base;
        tbl = '{'{46, 46}, '{10, 46}, '{0, 46}, '{45, 46}, '{47, 47},
                '{1500, 1500}, '{1501, 1500}, '{2000, 1500}, '{2047, 1500}};
        exp_cnt = '{32'd0, 32'd0};
        gap = '{-1, -1};
        sofs = '{0, 0};
        cap_n = '{0, 0};
        tick(3);
        chk("rst_valid", if_a.mac_tx_valid, 0);
        chk("rst_data", if_a.mac_tx_data, 0);
        chk("rst_busy", busy_a, 0);
        chk("rst_cnt", cnt_a, 0);
        chk("rst_valid_b", if_b.mac_tx_valid, 0);
        rst = 1'b0;
        tick();

        len_a = 11'd46;
        push(0, 46, -1);
        pulse_a();
        chk("first_byte_latency_sof", if_a.mac_tx_sof, 1);
        chk("first_byte_latency_valid", if_a.mac_tx_valid, 1);
        chk("busy_at_sof", busy_a, 1);
        wait_bytes(0, 63, 100);
        chk("eof_on_byte63", if_a.mac_tx_eof, 1);
        chk("cnt_during_eof", cnt_a, 0);
        tick();
        chk("cnt_after_eof", cnt_a, 1);
        chk("valid_after_eof", if_a.mac_tx_valid, 0);
        chk("byte0", cap[0][0], 8'hFF);
        chk("byte8", cap[0][8], 8'h35);
        chk("byte11", cap[0][11], 8'h01);
        chk("byte12", cap[0][12], 8'h88);
        chk("byte13", cap[0][13], 8'hB5);
        chk("byte17", cap[0][17], 8'h00);
        chk("byte18", cap[0][18], 8'h04);
        chk("byte59", cap[0][59], 8'h2D);
        tick(11);
        chk("busy_last_ifg", busy_a, 1);
        tick();
        chk("busy_idle", busy_a, 0);

        for (int i = 0; i < 9; i++) begin
            len_a = 11'(tbl[i].plen);
            push(0, tbl[i].exp_len, -1);
            pulse_a();
            wait_drain(1700);
            chk($sformatf("vec%0d_cap_len", i), cap_n[0], 18 + tbl[i].exp_len);
            chk($sformatf("vec%0d_frame_cnt", i), cnt_a, exp_cnt[0]);
            wait_idle(50);
        end

        len_a = 11'd100;
        push(0, 100, -1); push(0, 100, 13); push(0, 100, 13);
        base = sofs[0];
        en_a = 1'b1;
        wait_sofs(0, base + 3, 1000);
        en_a = 1'b0;
        wait_drain(400);
        wait_idle(50);
        chk("b2b_frame_cnt", cnt_a, exp_cnt[0]);

        len_a = 11'd60;
        push(0, 60, -1);
        pulse_a();
        wait_bytes(0, 20, 100);
        len_a = 11'd200;
        wait_drain(300);
        wait_idle(50);

        len_a = 11'd50;
        push(0, 50, -1);
        en_a = 1'b1;
        wait_bytes(0, 30, 100);
        en_a = 1'b0;
        base = sofs[0];
        wait_drain(200);
        chk("busy_in_ifg", busy_a, 1);
        tick(12);
        chk("busy_after_ifg", busy_a, 0);
        tick(20);
        chk("no_restart", sofs[0], base);

        len_a = 11'd46;
        push(0, 46, -1);
        pulse_a();
        wait_bytes(0, 40, 100);
        rst = 1'b1;
        tick();
        chk("rstmid_valid", if_a.mac_tx_valid, 0);
        chk("rstmid_sof", if_a.mac_tx_sof, 0);
        chk("rstmid_eof", if_a.mac_tx_eof, 0);
        chk("rstmid_busy", busy_a, 0);
        chk("rstmid_cnt", cnt_a, 0);
        rst = 1'b0;
        sb.delete();
        exp_cnt = '{32'd0, 32'd0};
        tick();
        push(0, 46, -1);
        pulse_a();
        wait_drain(200);
        wait_idle(50);
        chk("post_reset_cnt", cnt_a, 1);

        len_b = 11'd46;
        push(1, 46, -1); push(1, 46, 1); push(1, 46, 1);
        en_b = 1'b1;
        wait_sofs(1, 3, 500);
        en_b = 1'b0;
        wait_drain(300);
        wait_idle(50);
        chk("nofcs_frame_cnt", cnt_b, exp_cnt[1]);

        force dut_a.r_frame_cnt = 32'hFFFF_FFFF;
        tick();
        release dut_a.r_frame_cnt;
        tick();
        chk("preload_cnt", cnt_a, 32'hFFFF_FFFF);
        exp_cnt[0] = 32'hFFFF_FFFF;
        push(0, 46, -1); push(0, 46, 13);
        base = sofs[0];
        en_a = 1'b1;
        wait_sofs(0, base + 2, 300);
        en_a = 1'b0;
        wait_drain(200);
        wait_idle(50);
        chk("wrap_frame_cnt", cnt_a, exp_cnt[0]);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule

// File: doc/mac_tx_frame_gen.md
Name: mac_tx_frame_gen

Overview:
- Generates Ethernet test frames on the MAC transmit byte interface (mac_tx_data/valid/sof/eof) of mac_rgmii.
- Counterpart of the rx error checker: frames carry a sequence number and a known payload pattern, so a far-end receiver can verify fr_good and detect drops.
- Sits in the mac_gtx_clk domain and replaces the rx-to-tx loopback when traffic is self-generated.
- Emits frames starting at the destination MAC. mac_rgmii adds preamble/SFD; this block optionally appends the FCS.

Parameters:
- DST_MAC, 48'hFFFF_FFFF_FFFF, destination MAC address, sent MSB byte first.
- SRC_MAC, 48'h000A_3500_0001, source MAC address, sent MSB byte first.
- ETHERTYPE, 16'h88B5, EtherType field, sent MSB byte first.
- IFG_CYCLES, 12, minimum idle cycles between eof and the next sof. Range 0..255.
- APPEND_FCS, 1, 1 = append CRC-32 FCS (4 bytes); 0 = frame ends with the last payload byte.

Ports:
- clk, in, 1, byte clock (mac_gtx_clk, 125 MHz).
- rst, in, 1, synchronous active-high reset.
- enable, in, 1, generate frames back-to-back while high.
- payload_len, in, 11, payload byte count. Latched at frame start.
- mac_tx_data, out, 8, transmit byte.
- mac_tx_valid, out, 1, byte qualifier.
- mac_tx_sof, out, 1, first byte of frame.
- mac_tx_eof, out, 1, last byte of frame.
- busy, out, 1, frame or IFG in progress.
- frame_cnt, out, 32, count of completed frames.

Behaviour:
- Reset (synchronous, active-high):
  - All outputs 0 on the clock edge where rst=1.
  - FSM returns to IDLE and the sequence number is cleared.
  - Reset mid-frame truncates the frame immediately; no eof is emitted.
- FSM states: IDLE, HDR, PAY, FCS, IFG.
- IDLE:
  - If enable=1, latch the length and go to HDR.
  - The first byte (sof=1, valid=1) appears on the next clock, i.e. 1-cycle latency from enable sampled high.
- Length latch:
  - Latched value = payload_len clamped to the range 46..1500.
  - <46 gives 46; >1500 gives 1500.
  - Changing payload_len mid-frame has no effect on the current frame.
- HDR, 14 bytes, in order: DST_MAC, SRC_MAC, ETHERTYPE.
- PAY, L bytes (L = latched length):
  - Bytes 0..3 = sequence number, big-endian. The sequence number equals frame_cnt at frame start.
  - Byte k for k>=4 = k[7:0].
- FCS (only when APPEND_FCS=1):
  - Ethernet CRC-32: reflected poly 0xEDB88320, init 0xFFFFFFFF, computed over DST through the last payload byte, processed one byte per cycle.
  - Transmitted value = ~crc, least-significant byte first.
- Streaming:
  - mac_tx_valid stays high on every cycle from sof to eof; there is no backpressure.
  - sof is high only on the first byte.
  - eof is high only on the last byte: FCS byte 3, or payload byte L-1 when APPEND_FCS=0.
  - Frame length = 14+L+4 bytes (with FCS) or 14+L bytes (without).
- Idle outputs: whenever valid=0, mac_tx_data=0, sof=0, eof=0.
- IFG:
  - After eof, exactly IFG_CYCLES cycles with valid=0, then return to IDLE.
  - With IFG_CYCLES=0, go straight to IDLE.
  - IDLE takes one cycle to restart, so the minimum gap is IFG_CYCLES+1 cycles.
- frame_cnt:
  - Increments by 1 on the cycle after the eof byte.
  - Wraps 0xFFFFFFFF to 0; the sequence number wraps with it.
- busy: high from the sof cycle through the last IFG cycle; low in IDLE.
- enable deasserted mid-frame: the current frame and its IFG complete normally, then the block stays in IDLE.
- enable re-asserted during IFG: no early start; the IFG always completes.

Test Plan:
- Single frame, payload_len=46, APPEND_FCS=1, enable pulsed 1 cycle in IDLE:
  - 64 contiguous valid bytes with sof on byte 0 and eof on byte 63.
  - Bytes 0..5=FF, 6..11=00 0A 35 00 00 01, 12..13=88 B5, 14..17=00 00 00 00, 18=04 … 59=2D.
  - Bytes 60..63 match the golden CRC-32 model.
  - frame_cnt=1 afterwards.
- enable held high, payload_len=100, IFG_CYCLES=12:
  - Three frames of 118 bytes with sequence numbers 0, 1, 2.
  - Exactly 13 valid=0 cycles between each eof and the next sof.
- Length clamps: payload_len=10 gives a 64-byte frame; payload_len=2000 gives a 1518-byte frame.
- Mid-frame events:
  - Change payload_len during byte 20: no effect on the current frame.
  - Deassert enable at byte 30: the frame completes to eof, then idle with busy low after the IFG.
- Reset at byte 40 of a frame:
  - Next cycle valid, sof, eof, busy and frame_cnt all 0.
  - The following frame carries sequence number 0.
- APPEND_FCS=0, IFG_CYCLES=0, payload_len=46, enable high:
  - 60-byte frames with eof on payload byte 45.
  - Exactly 1 idle cycle between frames.
- Frame_cnt preload to 0xFFFFFFFF via force: the frame after the wrap carries sequence number 0.
